sm1118_color_sensor: RTL and testbench
======================================

// Module: sm1118_color_sensor
// PURPOSE
//  Drives a TCS3200-style colour sensor and classifies the dominant colour into the 2-bit
//  code consumed by the on-bot RGB LED indicator block.
//  Output codes: 00 = none/init, 01 = red, 10 = blue, 11 = green.
//  Measurement: select each photodiode filter, let it settle, then count rising edges of the
//  sensor's frequency output over a fixed gate window. Compare the R/G/B counts.
//  Runs on the 800 kHz system clock, between the sensor pins and the LED/indicator logic.
// PARAMETERS
//  CNT_W          16     width of per-channel edge counters (saturating)
//  GATE_CYCLES    8000   clk cycles per counting window (10 ms at 800 kHz)
//  SETTLE_CYCLES  80     clk cycles after filter switch before counting
//  MIN_COUNT      20     dominant channel count must be >= this, else result 00
//  SCALE          2'b10  {s0,s1} output-frequency scaling while active (20%)
// PORTS
//  clk          in   1      system clock, 800 kHz
//  reset        in   1      synchronous, active-high reset
//  en           in   1      1 = measure continuously; 0 = return to IDLE
//  sensor_out   in   1      sensor frequency output, asynchronous
//  s0, s1       out  1      frequency scaling select; 00 = sensor power-down
//  s2, s3       out  1      filter select: 00 red, 11 green, 01 blue
//  color        out  2      last classified colour code, held between results
//  color_valid  out  1      one-cycle pulse when color is updated
//  busy         out  1      1 in any state except IDLE
// BEHAVIOUR
//  - Reset values: s0=s1=s2=s3=0, color=00, color_valid=0, busy=0.
//    All counters cleared; FSM in IDLE.
//  - sensor_out input path: passes through a 2-FF synchroniser. A rising edge = sync'd bit is 1
//    and its previous value was 0. Edges reach the counter 3 cycles after the pin transition.
//  - FSM: IDLE -> SET_R -> CNT_R -> SET_G -> CNT_G -> SET_B -> CNT_B -> DECIDE.
//    * IDLE: {s0,s1}=00. Moves to SET_R on the first cycle en=1.
//    * SET_x: drives {s2,s3} for channel x and {s0,s1}=SCALE. Clears the x counter.
//      Stays SETTLE_CYCLES cycles. Edges during SET_x are ignored.
//    * CNT_x: lasts exactly GATE_CYCLES cycles.
//      Each detected edge increments the x count; the count saturates at 2^CNT_W-1.
//    * DECIDE: one cycle. On the next edge, color and color_valid=1 are registered.
//      Then: en=1 -> SET_R; en=0 -> IDLE.
//  - Classification, on the R/G/B counts:
//    * winner = channel strictly greater than both others -> its code.
//    * any tie for maximum -> 00.
//    * winner < MIN_COUNT -> 00.
//    * saturated counts compare as equal values.
//  - Latency: en is sampled 1 in IDLE at cycle 0. color_valid is high at cycle
//    3*(SETTLE_CYCLES+GATE_CYCLES)+2. It repeats every 3*(SETTLE+GATE)+1 cycles while en=1.
//  - en=0 in any non-IDLE state: next state is IDLE.
//    The partial measurement is discarded; color keeps its last value; no color_valid pulse.
//  - reset mid-measurement: all outputs return to reset values on that clock edge.
//    color returns to 00.
//  - color_valid is never high for two consecutive cycles.
//  - color changes only together with a color_valid pulse.
// TESTING
//  (Bench params: GATE_CYCLES=800, SETTLE_CYCLES=10, CNT_W=16, MIN_COUNT=20.)
//  1. reset=1 for 2 cycles, en=1 -> all outputs 0, busy=0.
//     After release: busy=1 next cycle, {s0,s1}=10, {s2,s3}=00.
//  2. sensor_out period 8 clk while s2s3=00, period 32 clk otherwise -> R~100, G~B~25 (+/-1).
//     Result: color=01, one color_valid pulse at cycle 2432.
//  3. Period 16 for green, 32 for red and blue -> color=11.
//     Then switch to blue dominant -> next result color=10.
//  4. Equal period 16 on all filters -> tie -> color=00, color_valid still pulses.
//  5. Period 64 on red, sensor held low otherwise -> R=12 < MIN_COUNT -> color=00.
//  6. After a red result, drop en for 1 cycle during CNT_G -> IDLE, {s0,s1}=00.
//     color stays 01, no pulse. Re-raise en -> fresh cycle from SET_R.
//     Also: CNT_W=8 with green period 2 -> G saturates at 255, color=11.

Source files
------------

// File: rtl/sm1118_color_sensor.sv
// TCS3200-style colour sensor driver and dominant-colour classifier.
// Codes: 00 none, 01 red, 10 blue, 11 green.
module sm1118_color_sensor #(
  parameter int         CNT_W         = 16,
  parameter int         GATE_CYCLES   = 8000,
  parameter int         SETTLE_CYCLES = 80,
  parameter int         MIN_COUNT     = 20,
  parameter logic [1:0] SCALE         = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sensor_out,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic [1:0] color,
  output logic       color_valid,
  output logic       busy
);

  localparam int TW =
    $clog2((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES) + 1;
  localparam logic [TW-1:0] GATE_LD = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SET_LD  = TW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_COUNT);

  typedef enum logic [2:0] {
    IDLE, SET_R, CNT_R, SET_G, CNT_G, SET_B, CNT_B, DECIDE
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [1:0]       sync_q;
  logic             prev_q;
  logic             edge_w;
  logic [CNT_W-1:0] cnt_r_q, cnt_g_q, cnt_b_q;
  logic [1:0]       code_d;

  assign edge_w = sync_q[1] & ~prev_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] filt(input state_t s);
    case (s)
      SET_G, CNT_G:          return 2'b11;
      SET_B, CNT_B, DECIDE:  return 2'b01;
      default:               return 2'b00;
    endcase
  endfunction

  // Next state and phase timer; en low aborts any measurement.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SET_R;
          tmr_d   = SET_LD;
        end
      end
      SET_R, SET_G, SET_B: begin
        if (tmr_q == '0) begin
          state_d = state_t'(state_q + 3'd1);
          tmr_d   = GATE_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      CNT_R, CNT_G: begin
        if (tmr_q == '0) begin
          state_d = state_t'(state_q + 3'd1);
          tmr_d   = SET_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      CNT_B: begin
        if (tmr_q == '0) state_d = DECIDE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      DECIDE: begin
        state_d = SET_R;
        tmr_d   = SET_LD;
      end
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  // Strict winner above the minimum count; ties and weak signals give 00.
  always_comb begin
    code_d = 2'b00;
    if (cnt_r_q > cnt_g_q && cnt_r_q > cnt_b_q && cnt_r_q >= MIN_C)
      code_d = 2'b01;
    else if (cnt_g_q > cnt_r_q && cnt_g_q > cnt_b_q && cnt_g_q >= MIN_C)
      code_d = 2'b11;
    else if (cnt_b_q > cnt_r_q && cnt_b_q > cnt_g_q && cnt_b_q >= MIN_C)
      code_d = 2'b10;
  end

  // State, synchroniser, edge counters and registered pin/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      cnt_r_q     <= '0;
      cnt_g_q     <= '0;
      cnt_b_q     <= '0;
      {s0, s1}    <= 2'b00;
      {s2, s3}    <= 2'b00;
      color       <= 2'b00;
      color_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      sync_q      <= {sync_q[0], sensor_out};
      prev_q      <= sync_q[1];
      busy        <= (state_d != IDLE);
      {s0, s1}    <= (state_d == IDLE) ? 2'b00 : SCALE;
      {s2, s3}    <= filt(state_d);
      color_valid <= (state_q == DECIDE);
      if (state_q == DECIDE) color <= code_d;
      if (state_q == SET_R) cnt_r_q <= '0;
      if (state_q == SET_G) cnt_g_q <= '0;
      if (state_q == SET_B) cnt_b_q <= '0;
      if (state_q == CNT_R && edge_w) cnt_r_q <= sat_inc(cnt_r_q);
      if (state_q == CNT_G && edge_w) cnt_g_q <= sat_inc(cnt_g_q);
      if (state_q == CNT_B && edge_w) cnt_b_q <= sat_inc(cnt_b_q);
    end
  end

endmodule

// File: tb/tb_sm1118_color_sensor.sv
// Directed bench for sm1118_color_sensor: timing, classification,
// abort, reset and counter saturation on a second narrow instance.
module tb_sm1118_color_sensor;

  localparam int PER = 3 * (10 + 800) + 1;

  logic clk;
  logic reset, en, sensor;
  logic s0, s1, s2, s3, cv, busy;
  logic [1:0] color;
  logic reset2, en2, sensor2;
  logic t0, t1, t2, t3, cv2, busy2;
  logic [1:0] color2;

  int per_r, per_g, per_b;
  int total, bad;
  int n;

  sm1118_color_sensor #(
    .CNT_W(16), .GATE_CYCLES(800), .SETTLE_CYCLES(10), .MIN_COUNT(20),
    .SCALE(2'b10)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .sensor_out(sensor),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .color(color), .color_valid(cv), .busy(busy)
  );

  sm1118_color_sensor #(
    .CNT_W(8), .GATE_CYCLES(800), .SETTLE_CYCLES(10), .MIN_COUNT(20),
    .SCALE(2'b10)
  ) dut8 (
    .clk(clk), .reset(reset2), .en(en2), .sensor_out(sensor2),
    .s0(t0), .s1(t1), .s2(t2), .s3(t3),
    .color(color2), .color_valid(cv2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sensor model: period chosen by the currently selected filter.
  initial begin
    int ph;
    int p;
    ph = 0;
    sensor = 1'b0;
    forever begin
      @(negedge clk);
      p = ({s2, s3} == 2'b11) ? per_g :
          ({s2, s3} == 2'b01) ? per_b : per_r;
      if (p == 0) sensor = 1'b0;
      else begin
        ph = (ph + 1) % p;
        sensor = (ph < p / 2);
      end
    end
  end

  // Narrow instance: green period 2 (400 edges), red 4 (200), blue 32.
  initial begin
    int ph;
    int p;
    ph = 0;
    sensor2 = 1'b0;
    forever begin
      @(negedge clk);
      p = ({t2, t3} == 2'b11) ? 2 : ({t2, t3} == 2'b01) ? 32 : 4;
      ph = (ph + 1) % p;
      sensor2 = (ph < p / 2);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!cv && cnt < 3000);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; en = 1'b1;
    reset2 = 1'b1; en2 = 1'b1;
    per_r = 8; per_g = 32; per_b = 32;
    step(2);
    chk("rst_pins", int'({s0, s1, s2, s3}), 0);
    chk("rst_color", int'(color), 0);
    chk("rst_valid", int'(cv), 0);
    chk("rst_busy", int'(busy), 0);

    reset = 1'b0; reset2 = 1'b0;
    step(1);
    chk("start_busy", int'(busy), 1);
    chk("start_scale", int'({s0, s1}), 2);
    chk("start_filt", int'({s2, s3}), 0);

    step(2430);
    chk("red_pre", int'(cv), 0);
    step(1);
    chk("red_valid", int'(cv), 1);
    chk("red_color", int'(color), 1);
    chk("sat_valid", int'(cv2), 1);
    chk("sat_color", int'(color2), 3);

    per_r = 32; per_g = 16;
    step(1);
    chk("one_pulse", int'(cv), 0);
    chk("red_hold", int'(color), 1);
    step(2429);
    chk("grn_pre", int'(cv), 0);
    step(1);
    chk("grn_valid", int'(cv), 1);
    chk("grn_color", int'(color), 3);

    per_g = 32; per_b = 8;
    wait_valid(n);
    chk("blu_lat", n, PER);
    chk("blu_color", int'(color), 2);

    per_r = 16; per_g = 16; per_b = 16;
    wait_valid(n);
    chk("tie_lat", n, PER);
    chk("tie_color", int'(color), 0);

    per_r = 8; per_g = 32; per_b = 32;
    wait_valid(n);
    chk("red2_color", int'(color), 1);

    per_r = 64; per_g = 0; per_b = 0;
    wait_valid(n);
    chk("weak_lat", n, PER);
    chk("weak_color", int'(color), 0);

    per_r = 8; per_g = 32; per_b = 32;
    wait_valid(n);
    chk("red3_color", int'(color), 1);

    step(900);
    chk("cntg_filt", int'({s2, s3}), 3);
    en = 1'b0;
    step(1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_scale", int'({s0, s1}), 0);
    chk("abort_color", int'(color), 1);
    chk("abort_valid", int'(cv), 0);
    en = 1'b1;
    step(1);
    chk("restart_busy", int'(busy), 1);
    chk("restart_filt", int'({s2, s3}), 0);
    wait_valid(n);
    chk("restart_lat", n, PER);
    chk("restart_color", int'(color), 1);

    step(500);
    reset = 1'b1;
    step(1);
    chk("mid_rst_color", int'(color), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_pins", int'({s0, s1, s2, s3}), 0);
    chk("mid_rst_valid", int'(cv), 0);
    reset = 1'b0; en = 1'b0;
    step(2);
    chk("idle_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
